dfd_event_counter: RTL and testbench
====================================

Name: dfd_event_counter

Overview:
- Programmable debug event counter for the DFD trace/monitor path.
- Accumulates multi-bit event increments while armed, with optional saturation and a sticky overflow flag.
- Captures on-demand snapshots into a holding register.
- Sits directly upstream of the clear-able holding flops in the monitor datapath:
  - produces the enable/clear/data that those stages register;
  - exposes a clean count/snapshot interface to the CSR readout.

Parameters:
- WIDTH, 16, counter and snapshot width in bits (legal: 4..64).
- INC_WIDTH, 4, width of the per-cycle increment amount (legal: 1..WIDTH).
- SATURATE, 1, 1 = saturate at all-ones and freeze; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  block clock; all state is updated on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  arm/resume counting.
- stop  input  1  pause counting (moves to FROZEN).
- clr  input  1  synchronous clear of count, overflow, snapshot-valid and state.
- inc_valid  input  1  increment qualifier.
- inc_amt  input  INC_WIDTH  increment amount, treated as unsigned.
- snap  input  1  snapshot request.
- count  output  WIDTH  live counter value (registered).
- snapshot  output  WIDTH  last captured count.
- snap_valid  output  1  one-cycle pulse: snapshot was updated.
- overflow  output  1  sticky carry-out indicator.
- state  output  2  current FSM state.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge): count=0, snapshot=0, snap_valid=0, overflow=0, state=IDLE. rst overrides every other input.
- State encoding: IDLE=2'b00, RUN=2'b01, FROZEN=2'b10; 2'b11 is illegal and recovers to IDLE on the next edge.
- Transition priority per cycle: rst > clr > start/stop > saturation event.
- IDLE:
  - start -> RUN.
  - stop, inc_valid and saturation are ignored.
- RUN:
  - stop -> FROZEN.
  - start is ignored.
  - SATURATE=1 and a carry-out occurs -> FROZEN.
- FROZEN:
  - start -> RUN (resumes from the held count).
  - stop is ignored.
- start and stop together: in IDLE or FROZEN, start wins; in RUN, stop wins.
- clr in any state:
  - next state = IDLE; count=0, overflow=0, snap_valid=0.
  - snapshot data is retained.
  - clr beats a simultaneous snap, so no capture occurs.
- Counting:
  - Only in RUN with inc_valid=1.
  - The increment is also accepted in the cycle where stop is asserted (the last counted cycle).
  - sum = {1'b0,count} + zero-extended inc_amt, computed WIDTH+1 bits wide.
  - Latency: count reflects the increment one cycle after inc_valid.
- Overflow (carry-out, sum[WIDTH]=1):
  - overflow is set and stays set until clr or rst.
  - SATURATE=1: count = all-ones, and state goes to FROZEN.
  - SATURATE=0: count = sum[WIDTH-1:0] (wraps); state is unchanged.
  - When SATURATE=1 and count is already all-ones, a zero inc_amt does not set overflow.
- Snapshot:
  - snap in cycle N (no clr) loads snapshot with the count register value of cycle N, i.e. before cycle N's increment.
  - snap_valid is high in cycle N+1 only.
  - snap in any state is honoured.
  - Back-to-back snap produces a pulse per cycle.
- Outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package dfd_event_counter_pkg:
  - state enum type dfd_evc_state_e (IDLE/RUN/FROZEN);
  - localparam widths for the state field.
- One natural sub-module: dfd_evc_accum.
  - Purely combinational adder with saturate/wrap select and carry detect.
  - Parameterised by WIDTH, INC_WIDTH and SATURATE.
- The FSM and all registers stay in the top module.

Test Plan (WIDTH=8 unless stated):
- Reset: rst held 2 cycles with start=1 -> count=0, state=IDLE, overflow=0, snap_valid=0 throughout; after release plus start -> state=RUN one cycle later.
- Basic count: start, then 5 cycles of inc_valid=1 with inc_amt=3 -> count=15 one cycle after the last increment; stop in the 5th cycle still counted (count=15), state=FROZEN.
- Saturate (SATURATE=1): count=250, inc_amt=9 -> count=255, overflow=1, state=FROZEN; a further start plus inc_amt=1 -> count stays 255, overflow stays 1.
- Wrap (SATURATE=0): count=250, inc_amt=9 -> count=3, overflow=1, state=RUN; clr -> count=0, overflow=0, state=IDLE next cycle.
- Snapshot timing: count=40 in RUN, inc_amt=2 with snap in the same cycle -> next cycle count=42, snapshot=40, snap_valid=1 for exactly one cycle.
- Simultaneous events: clr+snap+start in RUN -> state=IDLE, count=0, snap_valid=0, snapshot unchanged; start+stop in FROZEN -> RUN; forcing state=2'b11 via bind -> IDLE next cycle.

Source files
------------

// File: rtl/dfd_event_counter_pkg.sv
// Shared types and constants for the DFD debug event counter.
package dfd_event_counter_pkg;

  localparam int unsigned EVC_STATE_W = 2;

  typedef enum logic [EVC_STATE_W-1:0] {
    EVC_IDLE   = 2'b00,
    EVC_RUN    = 2'b01,
    EVC_FROZEN = 2'b10
  } dfd_evc_state_e;

endpackage : dfd_event_counter_pkg

// File: rtl/dfd_evc_accum.sv
// Combinational accumulator step: count + increment with carry detect and
// a saturate-or-wrap result select.
module dfd_evc_accum #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned INC_WIDTH = 4,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic [WIDTH-1:0]     count_in,
  input  logic [INC_WIDTH-1:0] inc_amt,
  output logic [WIDTH-1:0]     count_out,
  output logic                 carry
);

  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] sum;

  // The increment is unsigned, so it is zero-extended to the full sum width.
  assign inc_ext = (WIDTH+1)'(inc_amt);
  assign sum     = {1'b0, count_in} + inc_ext;
  assign carry   = sum[WIDTH];

  // On carry-out either clamp at all-ones or keep the wrapped low bits.
  always_comb begin
    count_out = sum[WIDTH-1:0];
    if (SATURATE && carry) begin
      count_out = '1;
    end
  end

endmodule : dfd_evc_accum

// File: rtl/dfd_event_counter.sv
// Programmable debug event counter: arm/pause FSM, multi-bit accumulation
// with sticky overflow, and an on-demand snapshot holding register.
module dfd_event_counter
  import dfd_event_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned INC_WIDTH = 4,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clr,
  input  logic                   inc_valid,
  input  logic [INC_WIDTH-1:0]   inc_amt,
  input  logic                   snap,
  output logic [WIDTH-1:0]       count,
  output logic [WIDTH-1:0]       snapshot,
  output logic                   snap_valid,
  output logic                   overflow,
  output logic [EVC_STATE_W-1:0] state
);

  dfd_evc_state_e   state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] snapshot_q, snapshot_d;
  logic             snap_valid_q, snap_valid_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] accum_next;
  logic             accum_carry;

  dfd_evc_accum #(
    .WIDTH    (WIDTH),
    .INC_WIDTH(INC_WIDTH),
    .SATURATE (SATURATE)
  ) u_accum (
    .count_in (count_q),
    .inc_amt  (inc_amt),
    .count_out(accum_next),
    .carry    (accum_carry)
  );

  // Next-state logic: clr first, then snapshot capture and the FSM with
  // counting, where stop wins over start in RUN and start wins elsewhere.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    snapshot_d   = snapshot_q;
    snap_valid_d = 1'b0;
    overflow_d   = overflow_q;

    if (clr) begin
      state_d    = EVC_IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (snap) begin
        snapshot_d   = count_q;
        snap_valid_d = 1'b1;
      end

      case (state_q)
        EVC_IDLE: begin
          if (start) begin
            state_d = EVC_RUN;
          end
        end
        EVC_RUN: begin
          if (inc_valid) begin
            count_d = accum_next;
            if (accum_carry) begin
              overflow_d = 1'b1;
            end
          end
          if (stop) begin
            state_d = EVC_FROZEN;
          end else if (SATURATE && inc_valid && accum_carry) begin
            state_d = EVC_FROZEN;
          end
        end
        EVC_FROZEN: begin
          if (start) begin
            state_d = EVC_RUN;
          end
        end
        default: begin
          state_d = EVC_IDLE;
        end
      endcase
    end
  end

  // All state registers with synchronous reset overriding every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EVC_IDLE;
      count_q      <= '0;
      snapshot_q   <= '0;
      snap_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      snapshot_q   <= snapshot_d;
      snap_valid_q <= snap_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign count      = count_q;
  assign snapshot   = snapshot_q;
  assign snap_valid = snap_valid_q;
  assign overflow   = overflow_q;
  assign state      = state_q;

endmodule : dfd_event_counter

// File: tb/tb_dfd_event_counter.sv
// Directed bench for dfd_event_counter: one saturating and one wrapping
// instance share the same stimulus and are checked against hand values.
module tb_dfd_event_counter;
  import dfd_event_counter_pkg::*;

  localparam int W  = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop, clr, inc_valid, snap;
  logic [IW-1:0] inc_amt;

  logic [W-1:0]  s_count, s_snapshot, w_count, w_snapshot;
  logic          s_snap_valid, s_overflow, w_snap_valid, w_overflow;
  logic [1:0]    s_state, w_state;

  int checks = 0;
  int errors = 0;

  dfd_event_counter #(.WIDTH(W), .INC_WIDTH(IW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
    .inc_valid(inc_valid), .inc_amt(inc_amt), .snap(snap),
    .count(s_count), .snapshot(s_snapshot), .snap_valid(s_snap_valid),
    .overflow(s_overflow), .state(s_state)
  );

  dfd_event_counter #(.WIDTH(W), .INC_WIDTH(IW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr),
    .inc_valid(inc_valid), .inc_amt(inc_amt), .snap(snap),
    .count(w_count), .snapshot(w_snapshot), .snap_valid(w_snap_valid),
    .overflow(w_overflow), .state(w_state)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle so outputs reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
    inc_valid = 1'b0; inc_amt = '0; snap = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (s_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", s_count); end
      checks++; if (s_state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", s_state); end
      checks++; if (s_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", s_overflow); end
      checks++; if (s_snap_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_snap_valid: got %0b expected 0", s_snap_valid); end
      checks++; if (s_snapshot !== 8'd0) begin errors++; $display("[TB] FAIL reset_snapshot: got %0d expected 0", s_snapshot); end
    end
    rst = 1'b0;
    tick();
    checks++; if (s_state !== 2'b01) begin errors++; $display("[TB] FAIL reset_then_start: got %0d expected 1", s_state); end
    start = 1'b0;
  endtask

  task automatic test_basic_count();
    inc_valid = 1'b1; inc_amt = 4'd3;
    for (int i = 1; i <= 5; i++) begin
      stop = (i == 5);
      tick();
      checks++; if (s_count !== 8'(3 * i)) begin errors++; $display("[TB] FAIL basic_count[%0d]: got %0d expected %0d", i, s_count, 3 * i); end
    end
    stop = 1'b0;
    checks++; if (s_state !== 2'b10) begin errors++; $display("[TB] FAIL basic_stop_state: got %0d expected 2", s_state); end
    tick();
    checks++; if (s_count !== 8'd15) begin errors++; $display("[TB] FAIL basic_frozen_hold: got %0d expected 15", s_count); end
    idle_inputs();
  endtask

  task automatic test_snapshot();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inc_valid = 1'b1;
    inc_amt = 4'd15; tick(); tick();
    inc_amt = 4'd10; tick();
    checks++; if (s_count !== 8'd40) begin errors++; $display("[TB] FAIL snap_setup: got %0d expected 40", s_count); end
    inc_amt = 4'd2; snap = 1'b1; tick();
    checks++; if (s_count !== 8'd42) begin errors++; $display("[TB] FAIL snap_count: got %0d expected 42", s_count); end
    checks++; if (s_snapshot !== 8'd40) begin errors++; $display("[TB] FAIL snap_data: got %0d expected 40", s_snapshot); end
    checks++; if (s_snap_valid !== 1'b1) begin errors++; $display("[TB] FAIL snap_valid_pulse: got %0b expected 1", s_snap_valid); end
    snap = 1'b0; inc_valid = 1'b0; tick();
    checks++; if (s_snap_valid !== 1'b0) begin errors++; $display("[TB] FAIL snap_valid_drop: got %0b expected 0", s_snap_valid); end
    checks++; if (s_snapshot !== 8'd40) begin errors++; $display("[TB] FAIL snap_hold: got %0d expected 40", s_snapshot); end
    // Back-to-back snapshots while counting by one each cycle.
    inc_valid = 1'b1; inc_amt = 4'd1; snap = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (s_snapshot !== 8'(42 + i)) begin errors++; $display("[TB] FAIL b2b_snap_data[%0d]: got %0d expected %0d", i, s_snapshot, 42 + i); end
      checks++; if (s_snap_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_snap_valid[%0d]: got %0b expected 1", i, s_snap_valid); end
    end
    idle_inputs(); tick();
    checks++; if (s_snap_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_snap_end: got %0b expected 0", s_snap_valid); end
  endtask

  task automatic test_saturate_wrap();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inc_valid = 1'b1; inc_amt = 4'd15;
    for (int i = 0; i < 16; i++) tick();
    inc_amt = 4'd10; tick();
    checks++; if (s_count !== 8'd250) begin errors++; $display("[TB] FAIL sat_setup: got %0d expected 250", s_count); end
    checks++; if (w_count !== 8'd250) begin errors++; $display("[TB] FAIL wrap_setup: got %0d expected 250", w_count); end
    inc_amt = 4'd9; tick();
    checks++; if (s_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 255", s_count); end
    checks++; if (s_overflow !== 1'b1) begin errors++; $display("[TB] FAIL sat_overflow: got %0b expected 1", s_overflow); end
    checks++; if (s_state !== 2'b10) begin errors++; $display("[TB] FAIL sat_state: got %0d expected 2", s_state); end
    checks++; if (w_count !== 8'd3) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 3", w_count); end
    checks++; if (w_overflow !== 1'b1) begin errors++; $display("[TB] FAIL wrap_overflow: got %0b expected 1", w_overflow); end
    checks++; if (w_state !== 2'b01) begin errors++; $display("[TB] FAIL wrap_state: got %0d expected 1", w_state); end
    inc_amt = 4'd1; start = 1'b1; tick(); start = 1'b0; tick();
    checks++; if (s_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold_count: got %0d expected 255", s_count); end
    checks++; if (s_overflow !== 1'b1) begin errors++; $display("[TB] FAIL sat_hold_overflow: got %0b expected 1", s_overflow); end
    checks++; if (s_state !== 2'b10) begin errors++; $display("[TB] FAIL sat_refreeze: got %0d expected 2", s_state); end
    checks++; if (w_count !== 8'd5) begin errors++; $display("[TB] FAIL wrap_continue: got %0d expected 5", w_count); end
    inc_valid = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (w_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_clr_count: got %0d expected 0", w_count); end
    checks++; if (w_overflow !== 1'b0) begin errors++; $display("[TB] FAIL wrap_clr_overflow: got %0b expected 0", w_overflow); end
    checks++; if (w_state !== 2'b00) begin errors++; $display("[TB] FAIL wrap_clr_state: got %0d expected 0", w_state); end
    // Land exactly on all-ones, then a zero increment must not flag overflow.
    start = 1'b1; tick(); start = 1'b0;
    inc_valid = 1'b1; inc_amt = 4'd15;
    for (int i = 0; i < 17; i++) tick();
    inc_amt = 4'd0; tick();
    checks++; if (s_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_exact_count: got %0d expected 255", s_count); end
    checks++; if (s_overflow !== 1'b0) begin errors++; $display("[TB] FAIL sat_zero_inc_overflow: got %0b expected 0", s_overflow); end
    checks++; if (s_state !== 2'b01) begin errors++; $display("[TB] FAIL sat_zero_inc_state: got %0d expected 1", s_state); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    inc_valid = 1'b1; inc_amt = 4'd7; tick();
    inc_valid = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    checks++; if (s_snapshot !== 8'd7) begin errors++; $display("[TB] FAIL simul_setup: got %0d expected 7", s_snapshot); end
    clr = 1'b1; snap = 1'b1; start = 1'b1; inc_valid = 1'b1; tick();
    idle_inputs();
    checks++; if (s_state !== 2'b00) begin errors++; $display("[TB] FAIL clr_prio_state: got %0d expected 0", s_state); end
    checks++; if (s_count !== 8'd0) begin errors++; $display("[TB] FAIL clr_prio_count: got %0d expected 0", s_count); end
    checks++; if (s_snap_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_prio_snap_valid: got %0b expected 0", s_snap_valid); end
    checks++; if (s_snapshot !== 8'd7) begin errors++; $display("[TB] FAIL clr_keeps_snapshot: got %0d expected 7", s_snapshot); end
    start = 1'b1; stop = 1'b1; tick();
    checks++; if (s_state !== 2'b01) begin errors++; $display("[TB] FAIL idle_start_stop: got %0d expected 1", s_state); end
    tick();
    checks++; if (s_state !== 2'b10) begin errors++; $display("[TB] FAIL run_start_stop: got %0d expected 2", s_state); end
    tick();
    checks++; if (s_state !== 2'b01) begin errors++; $display("[TB] FAIL frozen_start_stop: got %0d expected 1", s_state); end
    idle_inputs();
    force dut_sat.state_q = dfd_evc_state_e'(2'b11);
    #1;
    release dut_sat.state_q;
    tick();
    checks++; if (s_state !== 2'b00) begin errors++; $display("[TB] FAIL illegal_recover: got %0d expected 0", s_state); end
  endtask

  initial begin
    idle_inputs();
    $display("[TB] starting dfd_event_counter bench");
    test_reset();
    test_basic_count();
    test_snapshot();
    test_saturate_wrap();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dfd_event_counter
